// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
// The master side is the loader itself; the slave side feeds bytes and observes writes/status.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  rx_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;
   logic                  cpu_hold;
   logic                  done;
   logic                  error;

   modport master (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses MAGIC/LEN/words/CSUM frames, writes little-endian words into
// instruction memory and keeps the core held in reset until a frame verifies.
module imem_loader #(
   parameter int         ADDR_WIDTH = 10,
   parameter logic [7:0] MAGIC      = 8'hA5
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.master bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN0 = 3'd1,
      LEN1 = 3'd2,
      DATA = 3'd3,
      CSUM = 3'd4,
      DONE = 3'd5,
      ERR  = 3'd6
   } state_t;

   localparam logic [16:0] DEPTH_C = 17'd1 << ADDR_WIDTH;

   function automatic logic [7:0] csum_acc(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   state_t                state_r;
   logic                  rx_ready_r;
   logic                  we_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [31:0]           wdata_r;
   logic                  hold_r;
   logic                  done_r;
   logic                  error_r;
   logic [7:0]            len_lo_r;
   logic [15:0]           len_r;
   logic [ADDR_WIDTH:0]   idx_r;
   logic [1:0]            lane_r;
   logic [23:0]           word_r;
   logic [7:0]            xor_r;

   logic                  accept_s;
   logic [15:0]           len_in_s;
   logic [16:0]           idx_next_s;

   assign accept_s   = bus.rx_valid && rx_ready_r;
   assign len_in_s   = {bus.rx_data, len_lo_r};
   // Index is widened so a frame filling the whole memory still reaches its last word.
   assign idx_next_s = 17'(idx_r) + 17'd1;

   assign bus.rx_ready   = rx_ready_r;
   assign bus.imem_we    = we_r;
   assign bus.imem_addr  = addr_r;
   assign bus.imem_wdata = wdata_r;
   assign bus.cpu_hold   = hold_r;
   assign bus.done       = done_r;
   assign bus.error      = error_r;

   // Frame parser, word assembler and registered memory/status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         rx_ready_r <= 1'b0;
         we_r       <= 1'b0;
         addr_r     <= '0;
         wdata_r    <= 32'd0;
         hold_r     <= 1'b1;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         len_lo_r   <= 8'd0;
         len_r      <= 16'd0;
         idx_r      <= '0;
         lane_r     <= 2'd0;
         word_r     <= 24'd0;
         xor_r      <= 8'd0;
      end else begin
         rx_ready_r <= 1'b1;
         we_r       <= 1'b0;
         if (accept_s) begin
            case (state_r)
               IDLE, DONE, ERR: begin
                  if (bus.rx_data == MAGIC) begin
                     state_r <= LEN0;
                     xor_r   <= 8'd0;
                     idx_r   <= '0;
                     hold_r  <= 1'b1;
                     done_r  <= 1'b0;
                     error_r <= 1'b0;
                  end else begin
                     state_r <= state_r;
                  end
               end
               LEN0: begin
                  len_lo_r <= bus.rx_data;
                  xor_r    <= csum_acc(xor_r, bus.rx_data);
                  state_r  <= LEN1;
               end
               LEN1: begin
                  len_r  <= len_in_s;
                  xor_r  <= csum_acc(xor_r, bus.rx_data);
                  lane_r <= 2'd0;
                  if ({1'b0, len_in_s} > DEPTH_C) begin
                     state_r <= ERR;
                     error_r <= 1'b1;
                  end else if (len_in_s == 16'd0) begin
                     state_r <= CSUM;
                  end else begin
                     state_r <= DATA;
                  end
               end
               DATA: begin
                  xor_r  <= csum_acc(xor_r, bus.rx_data);
                  lane_r <= lane_r + 2'd1;
                  case (lane_r)
                     2'd0: word_r[7:0]   <= bus.rx_data;
                     2'd1: word_r[15:8]  <= bus.rx_data;
                     2'd2: word_r[23:16] <= bus.rx_data;
                     2'd3: begin
                        we_r    <= 1'b1;
                        addr_r  <= idx_r[ADDR_WIDTH-1:0];
                        wdata_r <= {bus.rx_data, word_r};
                        idx_r   <= idx_r + 1'b1;
                        if (idx_next_s == {1'b0, len_r}) begin
                           state_r <= CSUM;
                        end else begin
                           state_r <= DATA;
                        end
                     end
                     default: word_r <= word_r;
                  endcase
               end
               CSUM: begin
                  if (bus.rx_data == xor_r) begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                     hold_r  <= 1'b0;
                  end else begin
                     state_r <= ERR;
                     error_r <= 1'b1;
                  end
               end
               default: state_r <= IDLE;
            endcase
         end else begin
            state_r <= state_r;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 10-bit-address instance for normal frames and a
// 2-bit-address instance for the oversize/full-depth cases, selected by 'sel'.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tb_valid = 1'b0;
   logic [7:0]  tb_data = 8'd0;
   logic        sel = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int          wr_a = 0;
   int          wr_b = 0;
   logic [31:0] fw [0:7];
   logic [15:0] flen;

   imem_loader_if #(.ADDR_WIDTH(10)) ifa ();
   imem_loader_if #(.ADDR_WIDTH(2))  ifb ();

   assign ifa.rx_valid = tb_valid & ~sel;
   assign ifa.rx_data  = tb_data;
   assign ifb.rx_valid = tb_valid & sel;
   assign ifb.rx_data  = tb_data;

   imem_loader #(.ADDR_WIDTH(10), .MAGIC(8'hA5)) dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
   imem_loader #(.ADDR_WIDTH(2),  .MAGIC(8'hA5)) dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

   always #5 clk = ~clk;

   logic        mon_ready, mon_we, mon_hold, mon_done, mon_err;
   logic [9:0]  mon_addr;
   logic [31:0] mon_wdata;
   assign mon_ready = sel ? ifb.rx_ready : ifa.rx_ready;
   assign mon_we    = sel ? ifb.imem_we : ifa.imem_we;
   assign mon_hold  = sel ? ifb.cpu_hold : ifa.cpu_hold;
   assign mon_done  = sel ? ifb.done : ifa.done;
   assign mon_err   = sel ? ifb.error : ifa.error;
   assign mon_addr  = sel ? {8'd0, ifb.imem_addr} : ifa.imem_addr;
   assign mon_wdata = sel ? ifb.imem_wdata : ifa.imem_wdata;

   // Count write strobes per instance, one per cycle high.
   always @(negedge clk) begin
      if (ifa.imem_we === 1'b1) wr_a <= wr_a + 1;
      if (ifb.imem_we === 1'b1) wr_b <= wr_b + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      chk("rx_ready", 32'(mon_ready), 32'd1);
      tb_data  = b;
      tb_valid = 1'b1;
      @(posedge clk);
      #1;
      tb_valid = 1'b0;
   endtask

   task automatic send_gap(input logic [7:0] b, input bit gaps);
      int n;
      n = gaps ? int'($urandom_range(0, 3)) : 0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      send(b);
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      tb_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(mon_ready), 32'd0);
      chk("rst_we", 32'(mon_we), 32'd0);
      chk("rst_addr", 32'(mon_addr), 32'd0);
      chk("rst_wdata", mon_wdata, 32'd0);
      chk("rst_hold", 32'(mon_hold), 32'd1);
      chk("rst_done", 32'(mon_done), 32'd0);
      chk("rst_error", 32'(mon_err), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_ready", 32'(mon_ready), 32'd1);
   endtask

   // Sends fw[0..flen-1] as one frame; checks each write in the cycle after its lane-3 byte.
   task automatic send_frame(input bit corrupt, input bit gaps, input bit exp_ok);
      logic [7:0] x;
      logic [7:0] b;
      int         w0;
      w0 = sel ? wr_b : wr_a;
      send(8'hA5);
      chk("sof_hold", 32'(mon_hold), 32'd1);
      chk("sof_done", 32'(mon_done), 32'd0);
      chk("sof_error", 32'(mon_err), 32'd0);
      x = flen[7:0] ^ flen[15:8];
      send_gap(flen[7:0], gaps);
      send_gap(flen[15:8], gaps);
      for (int i = 0; i < int'(flen); i++) begin
         for (int k = 0; k < 4; k++) begin
            b = fw[i][8*k +: 8];
            x = x ^ b;
            send_gap(b, gaps);
            if (k == 3) begin
               chk("wr_we", 32'(mon_we), 32'd1);
               chk("wr_addr", 32'(mon_addr), 32'(i));
               chk("wr_data", mon_wdata, fw[i]);
            end else begin
               chk("no_we", 32'(mon_we), 32'd0);
            end
         end
      end
      chk("pre_csum_done", 32'(mon_done), 32'd0);
      send_gap(corrupt ? 8'h00 : x, gaps);
      chk("end_done", 32'(mon_done), 32'(exp_ok));
      chk("end_error", 32'(mon_err), 32'(!exp_ok));
      chk("end_hold", 32'(mon_hold), 32'(!exp_ok));
      chk("wr_count", 32'((sel ? wr_b : wr_a) - w0), 32'(flen));
   endtask

   initial begin
      int w0;
      sel = 1'b0;
      do_reset();

      // Two-word frame, good checksum then deliberately bad checksum.
      fw[0] = 32'h0000_0013;
      fw[1] = 32'h0010_0093;
      flen  = 16'd2;
      send_frame(1'b0, 1'b0, 1'b1);
      send_frame(1'b1, 1'b0, 1'b0);

      // Garbage in IDLE is discarded, then an empty frame verifies.
      do_reset();
      w0 = wr_a;
      send(8'h00);
      send(8'hFF);
      send(8'h5A);
      chk("garbage_done", 32'(mon_done), 32'd0);
      chk("garbage_wr", 32'(wr_a - w0), 32'd0);
      flen = 16'd0;
      send_frame(1'b0, 1'b0, 1'b1);

      // Three words with MAGIC bytes inside the payload, without and with rx_valid gaps.
      fw[0] = 32'h00A5_00A5;
      fw[1] = 32'hDEAD_BEEF;
      fw[2] = 32'hA5A5_1234;
      flen  = 16'd3;
      send_frame(1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 1'b1, 1'b1);

      // Small-memory instance: oversize length rejected, full-depth frame accepted.
      sel = 1'b1;
      w0  = wr_b;
      chk("b_idle_error", 32'(mon_err), 32'd0);
      send(8'hA5);
      send(8'h05);
      chk("b_len1_error", 32'(mon_err), 32'd0);
      send(8'h00);
      chk("b_over_error", 32'(mon_err), 32'd1);
      chk("b_over_hold", 32'(mon_hold), 32'd1);
      chk("b_over_done", 32'(mon_done), 32'd0);
      chk("b_over_wr", 32'(wr_b - w0), 32'd0);
      fw[0] = 32'h1111_1111;
      fw[1] = 32'h2222_2222;
      fw[2] = 32'h3333_3333;
      fw[3] = 32'h4444_4444;
      flen  = 16'd4;
      send_frame(1'b0, 1'b0, 1'b1);

      // Reset mid-word drops the partial word; a fresh frame then loads from address 0.
      sel = 1'b0;
      w0  = wr_a;
      send(8'hA5);
      send(8'h01);
      send(8'h00);
      send(8'h13);
      send(8'h00);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_ready", 32'(mon_ready), 32'd0);
      chk("mid_rst_we", 32'(mon_we), 32'd0);
      chk("mid_rst_hold", 32'(mon_hold), 32'd1);
      chk("mid_rst_done", 32'(mon_done), 32'd0);
      chk("mid_rst_wdata", mon_wdata, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_wr", 32'(wr_a - w0), 32'd0);
      fw[0] = 32'hCAFE_F00D;
      flen  = 16'd1;
      send_frame(1'b0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
